// File: rtl/ram.sv
// Two-write, two-read flip-flop RAM; write port 1 wins on an address collision.
// Latency: 1 cycle for reads (registered outputs), writes visible from the next edge.
// Backpressure: none; every enabled access completes on the edge it is sampled.
module ram #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 3,
    parameter int rst_mode  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_w1_n,
    input  logic [ADDRWIDTH-1:0] addr_w1,
    input  logic [DATAWIDTH-1:0] data_w1,
    input  logic                 en_w2_n,
    input  logic [ADDRWIDTH-1:0] addr_w2,
    input  logic [DATAWIDTH-1:0] data_w2,
    input  logic                 en_r1_n,
    input  logic [ADDRWIDTH-1:0] addr_r1,
    output logic [DATAWIDTH-1:0] data_r1,
    input  logic                 en_r2_n,
    input  logic [ADDRWIDTH-1:0] addr_r2,
    output logic [DATAWIDTH-1:0] data_r2
);

    localparam int DEPTH = 2 ** ADDRWIDTH;

    logic [DEPTH-1:0][DATAWIDTH-1:0] mem_q;
    logic [DEPTH-1:0][DATAWIDTH-1:0] mem_d;
    logic [DATAWIDTH-1:0]            data_r1_q;
    logic [DATAWIDTH-1:0]            data_r1_d;
    logic [DATAWIDTH-1:0]            data_r2_q;
    logic [DATAWIDTH-1:0]            data_r2_d;

    // Next memory image: port 2 applied first so port 1 overwrites it on a collision.
    always_comb begin
        mem_d = mem_q;
        if (!en_w2_n) begin
            mem_d[addr_w2] = data_w2;
        end
        if (!en_w1_n) begin
            mem_d[addr_w1] = data_w1;
        end
    end

    // Read next-state reads the current (pre-write) array, giving read-before-write.
    always_comb begin
        data_r1_d = data_r1_q;
        data_r2_d = data_r2_q;
        if (!en_r1_n) begin
            data_r1_d = mem_q[addr_r1];
        end
        if (!en_r2_n) begin
            data_r2_d = mem_q[addr_r2];
        end
    end

    generate
        if (rst_mode == 0) begin : g_mem_clr
            // Storage array, cleared asynchronously by reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q <= '0;
                end else begin
                    mem_q <= mem_d;
                end
            end
        end else begin : g_mem_keep
            // Storage array that survives reset; writes are blocked while reset is low.
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    mem_q <= mem_d;
                end
            end
        end
    endgenerate

    // Registered read outputs, forced to zero while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r1_q <= '0;
            data_r2_q <= '0;
        end else begin
            data_r1_q <= data_r1_d;
            data_r2_q <= data_r2_d;
        end
    end

    assign data_r1 = data_r1_q;
    assign data_r2 = data_r2_q;

endmodule

// File: tb/tb_ram.sv
module tb_ram;

    logic        clk;
    logic        rst_n;
    logic        en_w1_n;
    logic [2:0]  addr_w1;
    logic [63:0] data_w1;
    logic        en_w2_n;
    logic [2:0]  addr_w2;
    logic [63:0] data_w2;
    logic        en_r1_n;
    logic [2:0]  addr_r1;
    logic        en_r2_n;
    logic [2:0]  addr_r2;

    logic [63:0] a_r1;
    logic [63:0] a_r2;
    logic [7:0]  b_r1;
    logic [7:0]  b_r2;

    int n_checks;
    int n_errors;

    // Reference models: A is 64-bit with memory clear on reset, B is 8-bit keeping memory.
    logic [63:0] mdl_a [8];
    logic [7:0]  mdl_b [8];
    logic [63:0] hold_a1, hold_a2;
    logic [7:0]  hold_b1, hold_b2;

    logic [63:0] q_a1 [$];
    logic [63:0] q_a2 [$];
    logic [7:0]  q_b1 [$];
    logic [7:0]  q_b2 [$];

    ram #(.DATAWIDTH(64), .ADDRWIDTH(3), .rst_mode(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .en_w1_n(en_w1_n), .addr_w1(addr_w1), .data_w1(data_w1),
        .en_w2_n(en_w2_n), .addr_w2(addr_w2), .data_w2(data_w2),
        .en_r1_n(en_r1_n), .addr_r1(addr_r1), .data_r1(a_r1),
        .en_r2_n(en_r2_n), .addr_r2(addr_r2), .data_r2(a_r2)
    );

    ram #(.DATAWIDTH(8), .ADDRWIDTH(3), .rst_mode(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .en_w1_n(en_w1_n), .addr_w1(addr_w1), .data_w1(data_w1[7:0]),
        .en_w2_n(en_w2_n), .addr_w2(addr_w2), .data_w2(data_w2[7:0]),
        .en_r1_n(en_r1_n), .addr_r1(addr_r1), .data_r1(b_r1),
        .en_r2_n(en_r2_n), .addr_r2(addr_r2), .data_r2(b_r2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        en_w1_n = 1'b1; addr_w1 = '0; data_w1 = '0;
        en_w2_n = 1'b1; addr_w2 = '0; data_w2 = '0;
        en_r1_n = 1'b1; addr_r1 = '0;
        en_r2_n = 1'b1; addr_r2 = '0;
    endtask

    // Drive one cycle at the falling edge, score it, and check after the next rising edge.
    task automatic step(input logic w1n, input logic [2:0] aw1, input logic [63:0] dw1,
                        input logic w2n, input logic [2:0] aw2, input logic [63:0] dw2,
                        input logic r1n, input logic [2:0] ar1,
                        input logic r2n, input logic [2:0] ar2, input string tag);
        logic [63:0] e64;
        logic [7:0]  e8;
        en_w1_n = w1n; addr_w1 = aw1; data_w1 = dw1;
        en_w2_n = w2n; addr_w2 = aw2; data_w2 = dw2;
        en_r1_n = r1n; addr_r1 = ar1;
        en_r2_n = r2n; addr_r2 = ar2;
        if (!r1n) begin hold_a1 = mdl_a[ar1]; hold_b1 = mdl_b[ar1]; end
        if (!r2n) begin hold_a2 = mdl_a[ar2]; hold_b2 = mdl_b[ar2]; end
        q_a1.push_back(hold_a1); q_a2.push_back(hold_a2);
        q_b1.push_back(hold_b1); q_b2.push_back(hold_b2);
        if (!w2n) begin mdl_a[aw2] = dw2; mdl_b[aw2] = dw2[7:0]; end
        if (!w1n) begin mdl_a[aw1] = dw1; mdl_b[aw1] = dw1[7:0]; end
        @(posedge clk);
        @(negedge clk);
        e64 = (q_a1.size() != 0) ? q_a1.pop_front() : 'x; chk({tag, "_a_r1"}, a_r1, e64);
        e64 = (q_a2.size() != 0) ? q_a2.pop_front() : 'x; chk({tag, "_a_r2"}, a_r2, e64);
        e8  = (q_b1.size() != 0) ? q_b1.pop_front() : 'x; chk({tag, "_b_r1"}, {56'd0, b_r1}, {56'd0, e8});
        e8  = (q_b2.size() != 0) ? q_b2.pop_front() : 'x; chk({tag, "_b_r2"}, {56'd0, b_r2}, {56'd0, e8});
    endtask

    // Reset pulse asserted mid-cycle, held across one edge with accesses pending.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_a_r1", a_r1, 64'd0);
        chk("rst_async_a_r2", a_r2, 64'd0);
        chk("rst_async_b_r1", {56'd0, b_r1}, 64'd0);
        chk("rst_async_b_r2", {56'd0, b_r2}, 64'd0);
        for (int i = 0; i < 8; i++) mdl_a[i] = '0;
        hold_a1 = '0; hold_a2 = '0; hold_b1 = '0; hold_b2 = '0;
        en_w1_n = 1'b0; addr_w1 = 3'd5; data_w1 = 64'hDEAD_BEEF_0000_0077;
        en_w2_n = 1'b0; addr_w2 = 3'd6; data_w2 = 64'h1234_0000_0000_0066;
        en_r1_n = 1'b0; addr_r1 = 3'd0;
        en_r2_n = 1'b0; addr_r2 = 3'd1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_a_r1", a_r1, 64'd0);
        chk("rst_hold_b_r2", {56'd0, b_r2}, 64'd0);
        idle();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] names [5];
        n_checks = 0;
        n_errors = 0;
        names[0] = "Nesrine";
        names[1] = "Sridhar";
        names[2] = "Yong";
        names[3] = "Rupkatha";
        names[4] = "Aart";
        for (int i = 0; i < 8; i++) begin mdl_a[i] = '0; mdl_b[i] = 'x; end
        hold_a1 = '0; hold_a2 = '0; hold_b1 = '0; hold_b2 = '0;
        idle();
        rst_n = 1'b0;
        #1;
        chk("init_a_r1", a_r1, 64'd0);
        chk("init_b_r1", {56'd0, b_r1}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill every word using both ports on distinct addresses.
        for (int i = 0; i < 4; i++)
            step(1'b0, 3'(i), 64'h0101_0101_0101_0110 * (i + 1),
                 1'b0, 3'(i + 4), 64'h0F0F_0000_0000_0090 + i,
                 1'b1, 3'd0, 1'b1, 3'd0, "fill");

        // Name strings through write port 1, read back through port 1.
        for (int i = 0; i < 5; i++)
            step(1'b0, 3'(i), names[i], 1'b1, 3'd0, 64'd0,
                 1'b1, 3'd0, 1'b1, 3'd0, "names_wr");
        for (int i = 0; i < 5; i++)
            step(1'b1, 3'd0, 64'd0, 1'b1, 3'd0, 64'd0,
                 1'b0, 3'(i), 1'b0, 3'(4 - i), "names_rd");

        // Simultaneous writes to distinct addresses, then simultaneous reads.
        step(1'b0, 3'd1, 64'hAA, 1'b0, 3'd2, 64'hBB, 1'b1, 3'd0, 1'b1, 3'd0, "dual_wr");
        step(1'b1, 3'd0, 64'd0, 1'b1, 3'd0, 64'd0, 1'b0, 3'd1, 1'b0, 3'd2, "dual_rd");

        // Same-address collision: port 1 wins.
        step(1'b0, 3'd3, 64'hEE, 1'b0, 3'd3, 64'hCC, 1'b1, 3'd0, 1'b1, 3'd0, "coll_wr");
        step(1'b1, 3'd0, 64'd0, 1'b1, 3'd0, 64'd0, 1'b0, 3'd3, 1'b0, 3'd3, "coll_rd");

        // Read-before-write on the same edge.
        step(1'b0, 3'd4, 64'hCC, 1'b1, 3'd0, 64'd0, 1'b1, 3'd0, 1'b1, 3'd0, "rbw_pre");
        step(1'b0, 3'd4, 64'hFF, 1'b1, 3'd0, 64'd0, 1'b0, 3'd4, 1'b1, 3'd0, "rbw_old");
        step(1'b1, 3'd0, 64'd0, 1'b1, 3'd0, 64'd0, 1'b0, 3'd4, 1'b0, 3'd4, "rbw_new");

        // Disabled reads hold while the address wanders.
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'd0, 64'd0, 1'b1, 3'd0, 64'd0, 1'b1, 3'(i), 1'b1, 3'(7 - i), "hold");

        // Mid-cycle reset, then read every address back.
        mid_reset();
        for (int i = 0; i < 8; i++)
            step(1'b1, 3'd0, 64'd0, 1'b1, 3'd0, 64'd0, 1'b0, 3'(i), 1'b0, 3'(7 - i), "post_rst");

        // Random traffic.
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), "rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
